des_decrypt_iter: RTL

DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

---
 rtl/des_decrypt_iter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, 16 rounds plus a finish cycle.
// Subkeys are generated on the fly by rotating C/D right, so K16 is used first.
module des_decrypt_iter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [63:0] KEY,
  input  logic [63:0] CIPHER_TEXT,
  output logic [63:0] PLAIN_TEXT,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

  // Tables list DES bit positions (1 = MSB), first output bit first.
  localparam logic [0:63][6:0] IP_T = {
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,  7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};
  localparam logic [0:63][6:0] FP_T = {
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,  7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,  7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,  7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,  7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25};
  localparam logic [0:47][6:0] E_T = {
    7'd32, 7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd4,  7'd5,  7'd6,  7'd7,  7'd8,  7'd9,
    7'd8,  7'd9,  7'd10, 7'd11, 7'd12, 7'd13, 7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17,
    7'd16, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd20, 7'd21, 7'd22, 7'd23, 7'd24, 7'd25,
    7'd24, 7'd25, 7'd26, 7'd27, 7'd28, 7'd29, 7'd28, 7'd29, 7'd30, 7'd31, 7'd32, 7'd1};
  localparam logic [0:31][6:0] P_T = {
    7'd16, 7'd7,  7'd20, 7'd21, 7'd29, 7'd12, 7'd28, 7'd17, 7'd1,  7'd15, 7'd23, 7'd26, 7'd5,  7'd18, 7'd31, 7'd10,
    7'd2,  7'd8,  7'd24, 7'd14, 7'd32, 7'd27, 7'd3,  7'd9,  7'd19, 7'd13, 7'd30, 7'd6,  7'd22, 7'd11, 7'd4,  7'd25};
  localparam logic [0:55][6:0] PC1_T = {
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};
  localparam logic [0:47][6:0] PC2_T = {
    7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,  7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
    7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,  7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
    7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55, 7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
    7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53, 7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32};
  // Each S-box is 64 nibbles, row-major (row = b1b6, column = b2..b5).
  localparam logic [0:7][255:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};
  // Bit k set means shift schedule S(k) is 1 (k = 1, 2, 9, 16); otherwise 2.
  localparam logic [31:0] S_ONE = 32'h0001_0206;

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    for (int i = 0; i < 64; i++) perm_ip[63-i] = x[64-int'(IP_T[i])];
  endfunction
  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    for (int i = 0; i < 64; i++) perm_fp[63-i] = x[64-int'(FP_T[i])];
  endfunction
  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    for (int i = 0; i < 56; i++) perm_pc1[55-i] = x[64-int'(PC1_T[i])];
  endfunction
  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    for (int i = 0; i < 48; i++) perm_pc2[47-i] = x[56-int'(PC2_T[i])];
  endfunction
  function automatic logic [47:0] perm_e(input logic [31:0] x);
    for (int i = 0; i < 48; i++) perm_e[47-i] = x[32-int'(E_T[i])];
  endfunction
  function automatic logic [31:0] perm_p(input logic [31:0] x);
    for (int i = 0; i < 32; i++) perm_p[31-i] = x[32-int'(P_T[i])];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    logic [7:0]  idx;
    x = perm_e(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b   = x[47-6*i -: 6];
      idx = {2'b00, b[5], b[0], b[4:1]};
      s[31-4*i -: 4] = SBOX[i][255-4*int'(idx) -: 4];
    end
    return perm_p(s);
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  j_q, j_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_half_q, c_half_d, d_half_q, d_half_d;
  logic [63:0] pt_q, pt_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [63:0] ip_out;
  logic [55:0] pc1_out;
  logic        shift_one;

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    l_d       = l_q;
    r_d       = r_q;
    c_half_d  = c_half_q;
    d_half_d  = d_half_q;
    pt_d      = pt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ip_out    = perm_ip(CIPHER_TEXT);
    pc1_out   = perm_pc1(KEY);
    shift_one = S_ONE[5'd17 - j_q];
    case (state_q)
      IDLE: begin
        if (START) begin
          {l_d, r_d}           = ip_out;
          {c_half_d, d_half_d} = pc1_out;
          j_d                  = 5'd1;
          busy_d               = 1'b1;
          state_d              = ROUND;
        end
      end
      ROUND: begin
        l_d = r_q;
        r_d = l_q ^ feistel(r_q, perm_pc2({c_half_q, d_half_q}));
        // Right rotation walks the key schedule backwards from C16/D16 = C0/D0.
        if (shift_one) begin
          c_half_d = {c_half_q[0], c_half_q[27:1]};
          d_half_d = {d_half_q[0], d_half_q[27:1]};
        end else begin
          c_half_d = {c_half_q[1:0], c_half_q[27:2]};
          d_half_d = {d_half_q[1:0], d_half_q[27:2]};
        end
        if (j_q == 5'd16) state_d = FINISH;
        else              j_d     = j_q + 5'd1;
      end
      FINISH: begin
        pt_d    = perm_fp({r_q, l_q});
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      j_q      <= '0;
      l_q      <= '0;
      r_q      <= '0;
      c_half_q <= '0;
      d_half_q <= '0;
      pt_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      l_q      <= l_d;
      r_q      <= r_d;
      c_half_q <= c_half_d;
      d_half_q <= d_half_d;
      pt_q     <= pt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign PLAIN_TEXT = pt_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule
